// File: rtl/fbuf_pkg.sv
// Shared defaults, FSM state encoding and clear fill value for the framebuffer arbiter.
// The clear engine is built only when FBUF_CLEAR_EN is defined.
package fbuf_pkg;
  localparam int FB_ADDR_W = 9;
  localparam int FB_DATA_W = 16;
  localparam int FB_DEPTH  = 512;

  // Every bit of a cleared word takes this value.
  localparam logic CLR_FILL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACK,
    RD_WAIT,
    RD_ACK,
    CLEAR
  } state_t;
endpackage

// File: rtl/fbuf_clear.sv
// Clear engine: sweep address counter, busy flag and last-word detection.
// Instantiated by fbuf_arbiter only when FBUF_CLEAR_EN is defined.
module fbuf_clear
  import fbuf_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DEPTH  = FB_DEPTH
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              step,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic              busy_reg;
  logic [ADDR_W-1:0] cnt_reg;

  // Done fires in the cycle that writes the final word, so the sweep never wraps.
  assign done = busy_reg && step && (cnt_reg == LAST);
  assign busy = busy_reg;
  assign addr = cnt_reg;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start && !busy_reg) begin
      busy_reg <= 1'b1;
      cnt_reg  <= '0;
    end else if (done) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (busy_reg && step) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/fbuf_arbiter.sv
// Single-port framebuffer arbiter: display reads > CPU handshake > clear sweep.
// Optional clear engine enabled by defining FBUF_CLEAR_EN.
module fbuf_arbiter
  import fbuf_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int DEPTH  = FB_DEPTH
) (
  input  logic              clk,
  input  logic              res,
  input  logic              disp_rd,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_t            state_reg;
  logic              cpu_ack_reg;
  logic [DATA_W-1:0] cpu_rdata_reg;

  logic              clr_go;
  logic              clr_step;
  logic              clr_done;
  logic [ADDR_W-1:0] clr_addr;
  logic              grant;

`ifdef FBUF_CLEAR_EN
  assign clr_go   = (state_reg == IDLE) && clr_start;
  assign clr_step = (state_reg == CLEAR) && !disp_rd;

  fbuf_clear #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .clk   (clk),
    .res   (res),
    .start (clr_go),
    .step  (clr_step),
    .busy  (clr_busy),
    .addr  (clr_addr),
    .done  (clr_done)
  );
`else
  logic unused_cfg;
  assign unused_cfg = clr_start ^ (DEPTH == 0);
  assign clr_go     = 1'b0;
  assign clr_step   = 1'b0;
  assign clr_done   = 1'b0;
  assign clr_addr   = '0;
  assign clr_busy   = 1'b0;
`endif

  // Grant is qualified with res so a held request cannot drive the RAM during reset.
  assign grant = res && (state_reg == IDLE) && cpu_req && !disp_rd && !clr_go;

  assign disp_data = ram_rdata;
  assign cpu_ack   = cpu_ack_reg;
  assign cpu_rdata = cpu_rdata_reg;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (disp_rd) begin
      ram_addr = disp_addr;
    end else if (grant) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      if (cpu_we) ram_wdata = cpu_wdata;
    end else if (clr_step) begin
      ram_addr  = clr_addr;
      ram_we    = 1'b1;
      ram_wdata = {DATA_W{CLR_FILL}};
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg     <= IDLE;
      cpu_ack_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
    end else begin
      cpu_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (clr_go) begin
            state_reg <= CLEAR;
          end else if (grant) begin
            if (cpu_we) begin
              state_reg   <= WR_ACK;
              cpu_ack_reg <= 1'b1;
            end else begin
              state_reg <= RD_WAIT;
            end
          end
        end
        // ram_rdata here still belongs to the address presented in the grant cycle.
        RD_WAIT: begin
          cpu_rdata_reg <= ram_rdata;
          cpu_ack_reg   <= 1'b1;
          state_reg     <= RD_ACK;
        end
        WR_ACK:  state_reg <= IDLE;
        RD_ACK:  state_reg <= IDLE;
        CLEAR:   if (clr_done) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fbuf_arbiter.sv
// Directed bench for fbuf_arbiter with a behavioural synchronous RAM and a CPU scoreboard.
// Covers the clear engine when built with FBUF_CLEAR_EN.
module tb_fbuf_arbiter;
  logic        clk = 1'b0;
  logic        res;
  logic        disp_rd;
  logic [8:0]  disp_addr;
  logic [15:0] disp_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        clr_start;
  logic        clr_busy;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [512];

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  fbuf_arbiter dut (
    .clk       (clk),
    .res       (res),
    .disp_rd   (disp_rd),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Synchronous RAM, read-before-write, with a bench-only preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction granted immediately; exp_lat = negedges from drive to ack.
  task automatic cpu_op(input logic we, input logic [8:0] addr, input logic [15:0] data,
                        input int exp_lat, input string tag);
    int n;
    logic got;
    logic [15:0] exp;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = we ? data : 16'h0;
    sb.push_back(data);
    #1;
    chk({tag, "_grant_addr"}, 32'(ram_addr), 32'(addr));
    chk({tag, "_grant_we"}, 32'(ram_we), 32'(we));
    if (we) chk({tag, "_grant_wdata"}, 32'(ram_wdata), 32'(data));
    n = 0; got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      got = cpu_ack;
    end
    cpu_req = 1'b0;
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    exp = sb.pop_front();
    if (!we) chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp));
    $display("txn %s we=%0d addr=%03h data=%04h ack_after=%0d", tag, we, addr,
             we ? data : cpu_rdata, n);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, wes, nz, n, early;
    int ack_cyc [3];
    res = 1'b0; disp_rd = 0; disp_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0;
    cpu_wdata = '0; clr_start = 0; pre_we = 0; pre_addr = '0; pre_data = '0;
    repeat (2) @(negedge clk);
    // Reset values, with a request held high to show it cannot reach the RAM.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h055; cpu_wdata = 16'hFFFF;
    #1;
    chk("rst_ack", 32'(cpu_ack), 0);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_wdata", 32'(ram_wdata), 0);
    cpu_req = 1'b0;
    @(negedge clk);
    res = 1'b1;

    // Preload every word nonzero.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 9'(i);
      pre_data = (i == 32) ? 16'h1234 : (i == 33) ? 16'hBEEF : (16'h8000 | 16'(i));
    end
    @(negedge clk);
    pre_we = 1'b0;

    // Basic write then read.
    cpu_op(1'b1, 9'h012, 16'hA5A5, 1, "wr012");
    cpu_op(1'b0, 9'h012, 16'hA5A5, 2, "rd012");

    // Display read latency.
    @(negedge clk);
    disp_rd = 1'b1; disp_addr = 9'h012;
    @(negedge clk);
    disp_rd = 1'b0;
    chk("disp_data012", 32'(disp_data), 32'hA5A5);

    // Display holds off the CPU for five cycles.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h0FF; cpu_wdata = 16'h5555;
    disp_rd = 1'b1; disp_addr = 9'h100;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("contend_addr", 32'(ram_addr), 32'h100);
      chk("contend_we", 32'(ram_we), 0);
      @(negedge clk);
      chk("contend_noack", 32'(cpu_ack), 0);
    end
    disp_rd = 1'b0;
    #1;
    chk("contend_grant_addr", 32'(ram_addr), 32'h0FF);
    chk("contend_grant_we", 32'(ram_we), 1);
    @(negedge clk);
    chk("contend_ack", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
    $display("txn contend_wr addr=0ff data=5555");

    // CPU read with a display read interleaved in the RD_WAIT cycle.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h020;
    sb.push_back(16'h1234);
    #1;
    chk("rdmix_grant_addr", 32'(ram_addr), 32'h020);
    @(negedge clk);
    disp_rd = 1'b1; disp_addr = 9'h021;
    #1;
    chk("rdmix_disp_addr", 32'(ram_addr), 32'h021);
    chk("rdmix_g1_noack", 32'(cpu_ack), 0);
    @(negedge clk);
    disp_rd = 1'b0; cpu_req = 1'b0;
    chk("rdmix_ack", 32'(cpu_ack), 1);
    chk("rdmix_rdata", 32'(cpu_rdata), 32'(sb.pop_front()));
    chk("rdmix_disp_data", 32'(disp_data), 32'hBEEF);
    $display("txn rdmix addr=020 rdata=%04h disp=%04h", cpu_rdata, disp_data);

    // Back-to-back writes with the request held high.
    @(negedge clk);
    acks = 0; wes = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h030; cpu_wdata = 16'h1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ram_we) wes++;
      @(negedge clk);
      if (cpu_ack) begin
        if (acks < 3) ack_cyc[acks] = c + 1;
        acks++;
        cpu_addr = 9'h030 + 9'(acks);
        cpu_wdata = 16'h1111 * 16'(acks + 1);
        if (acks >= 3) cpu_req = 1'b0;
      end
    end
    chk("b2b_acks", 32'(acks), 3);
    chk("b2b_we_pulses", 32'(wes), 3);
    chk("b2b_ack0", 32'(ack_cyc[0]), 1);
    chk("b2b_ack1", 32'(ack_cyc[1]), 3);
    chk("b2b_ack2", 32'(ack_cyc[2]), 5);
    $display("txn b2b acks=%0d at %0d/%0d/%0d", acks, ack_cyc[0], ack_cyc[1], ack_cyc[2]);
    cpu_op(1'b0, 9'h031, 16'h2222, 2, "rd031");
    cpu_op(1'b0, 9'h032, 16'h3333, 2, "rd032");

`ifdef FBUF_CLEAR_EN
    // Full clear with a CPU write raised mid-sweep.
    @(negedge clk);
    clr_start = 1'b1;
    #1;
    chk("clr_start_we", 32'(ram_we), 0);
    @(negedge clk);
    clr_start = 1'b0;
    n = 0; early = 0;
    while (clr_busy && n < 2000) begin
      n++;
      if (n == 100) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h077; cpu_wdata = 16'h7777;
      end
      @(negedge clk);
      if (cpu_ack) early++;
    end
    chk("clr_busy_cycles", 32'(n), 512);
    chk("clr_no_early_ack", 32'(early), 0);
    @(negedge clk);
    chk("clr_cpu_ack_after", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
    $display("txn clear busy_cycles=%0d", n);
    nz = 0;
    for (int i = 0; i < 512; i++) if (i != 'h077 && mem[i] !== 16'h0) nz++;
    chk("clr_nonzero_words", 32'(nz), 0);
    cpu_op(1'b0, 9'h012, 16'h0000, 2, "rd012_cleared");
    cpu_op(1'b0, 9'h077, 16'h7777, 2, "rd077");
`else
    // Without the clear engine clr_start is ignored and the CPU wins.
    @(negedge clk);
    clr_start = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h040; cpu_wdata = 16'h4444;
    #1;
    chk("noclr_grant_we", 32'(ram_we), 1);
    chk("noclr_busy", 32'(clr_busy), 0);
    @(negedge clk);
    clr_start = 1'b0; cpu_req = 1'b0;
    chk("noclr_ack", 32'(cpu_ack), 1);
    chk("noclr_busy_after", 32'(clr_busy), 0);
    $display("txn noclr_wr addr=040 data=4444");
    cpu_op(1'b0, 9'h040, 16'h4444, 2, "rd040");
    cpu_op(1'b0, 9'h012, 16'hA5A5, 2, "rd012_kept");
`endif

    // Reset during RD_WAIT aborts the read.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h012;
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("abort_ack", 32'(cpu_ack), 0);
    chk("abort_rdata", 32'(cpu_rdata), 0);
    chk("abort_busy", 32'(clr_busy), 0);
    chk("abort_we", 32'(ram_we), 0);
    chk("abort_addr", 32'(ram_addr), 0);
    chk("abort_wdata", 32'(ram_wdata), 0);
    cpu_req = 1'b0;
    @(negedge clk);
    res = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("abort_no_late_ack", 32'(acks), 0);
    $display("txn abort_rd addr=012");
    cpu_op(1'b1, 9'h050, 16'hABCD, 1, "wr050_after_rst");
    cpu_op(1'b0, 9'h050, 16'hABCD, 2, "rd050_after_rst");

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
